// File: rtl/cl_soc_evt_hs.sv
// Cluster-to-SoC event handshake: per-channel pending counters with valid/ack FSMs.
// Optional sticky overflow flags are built only when PULP_CL_EVT_OVF_EN is defined.
module cl_soc_evt_hs #(
   parameter int NB_EVT    = 3,
   parameter int CNT_WIDTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NB_EVT-1:0] evt_pulse_i,
   output logic [NB_EVT-1:0] evt_valid_o,
   input  logic [NB_EVT-1:0] evt_ack_i,
   output logic [NB_EVT-1:0] evt_overflow_o,
   input  logic              ovf_clr_i,
   output logic              busy_o
);

   typedef enum logic [1:0] {IDLE, PEND, GAP} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [NB_EVT-1:0] w_cnt_nz;
   logic              r_busy;

   genvar gi;
   generate
      for (gi = 0; gi < NB_EVT; gi++) begin : g_ch
         state_t               r_state;
         logic [CNT_WIDTH-1:0] r_cnt;
         logic                 r_valid;
         logic                 w_pulse;
         logic                 w_ack;
         logic                 w_sat;
         logic [CNT_WIDTH-1:0] w_cnt_next;

         assign w_pulse = evt_pulse_i[gi];
         // Acks only mean something while an event is being presented.
         assign w_ack   = evt_ack_i[gi] && (r_state == PEND);
         assign w_sat   = (r_cnt == CNT_MAX);

         always_comb begin
            w_cnt_next = r_cnt;
            if (w_ack && !w_pulse)
               w_cnt_next = r_cnt - 1'b1;
            else if (!w_ack && w_pulse && !w_sat)
               w_cnt_next = r_cnt + 1'b1;
         end

         always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_valid <= 1'b0;
            end else begin
               r_cnt <= w_cnt_next;
               case (r_state)
                  IDLE: begin
                     if (w_pulse) begin
                        r_state <= PEND;
                        r_valid <= 1'b1;
                     end
                  end
                  PEND: begin
                     if (w_ack) begin
                        r_state <= GAP;
                        r_valid <= 1'b0;
                     end
                  end
                  GAP: begin
                     // Uses the updated count so a pulse landing in GAP is not stranded.
                     if (w_cnt_next != '0) begin
                        r_state <= PEND;
                        r_valid <= 1'b1;
                     end else begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                     end
                  end
                  default: begin
                     r_state <= IDLE;
                     r_valid <= 1'b0;
                  end
               endcase
            end
         end

         assign evt_valid_o[gi] = r_valid;
         assign w_cnt_nz[gi]    = (w_cnt_next != '0);

`ifdef PULP_CL_EVT_OVF_EN
         logic w_drop;
         logic r_ovf;

         assign w_drop = w_pulse && !w_ack && w_sat;

         always_ff @(posedge clk_i) begin
            if (!rst_ni)
               r_ovf <= 1'b0;
            else
               r_ovf <= (r_ovf && !ovf_clr_i) || w_drop;
         end

         assign evt_overflow_o[gi] = r_ovf;
`else
         assign evt_overflow_o[gi] = 1'b0;
`endif
      end
   endgenerate

`ifndef PULP_CL_EVT_OVF_EN
   logic w_unused_clr;
   assign w_unused_clr = ovf_clr_i;
`endif

   // Registered from next-state counters so busy lines up with the counter registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni)
         r_busy <= 1'b0;
      else
         r_busy <= |w_cnt_nz;
   end

   assign busy_o = r_busy;

endmodule

// File: tb/tb_cl_soc_evt_hs.sv
// Self-checking bench for cl_soc_evt_hs: directed scenarios plus randomized traffic
// compared every cycle against a count-based behavioural model.
module tb_cl_soc_evt_hs;

   localparam int NB  = 3;
   localparam int CW  = 4;
   localparam int MAX = (1 << CW) - 1;
`ifdef PULP_CL_EVT_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NB-1:0] pulse;
   logic [NB-1:0] ack;
   logic          clr;
   logic [NB-1:0] valid;
   logic [NB-1:0] ovf;
   logic          busy;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Model: pending count per channel, whether it is currently presented,
   // whether it is in the one-cycle gap after an ack, and the sticky flag.
   int m_cnt  [NB];
   bit m_pres [NB];
   bit m_gap  [NB];
   bit m_ovf  [NB];
   bit m_busy;

   cl_soc_evt_hs #(.NB_EVT(NB), .CNT_WIDTH(CW)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .evt_pulse_i    (pulse),
      .evt_valid_o    (valid),
      .evt_ack_i      (ack),
      .evt_overflow_o (ovf),
      .ovf_clr_i      (clr),
      .busy_o         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_step();
      bit acked, drop;
      m_busy = 1'b0;
      for (int i = 0; i < NB; i++) begin
         if (!rst_n) begin
            m_cnt[i] = 0; m_pres[i] = 0; m_gap[i] = 0; m_ovf[i] = 0;
         end else begin
            acked = ack[i] && m_pres[i];
            drop  = pulse[i] && !acked && (m_cnt[i] == MAX);
            m_cnt[i] = m_cnt[i] - int'(acked) + int'(pulse[i] && !drop);
            if (OVF_EN) m_ovf[i] = (m_ovf[i] && !clr) || drop;
            if (acked) begin
               m_pres[i] = 0; m_gap[i] = 1;
            end else if (m_gap[i]) begin
               m_gap[i] = 0; m_pres[i] = (m_cnt[i] > 0);
            end else if (!m_pres[i] && m_cnt[i] > 0) begin
               m_pres[i] = 1;
            end
         end
         if (m_cnt[i] > 0) m_busy = 1'b1;
      end
   endtask

   // Drive one cycle, advance the model on the edge, return at the following negedge.
   task automatic cyc(input logic [NB-1:0] p, input logic [NB-1:0] a, input logic c, input logic r);
      pulse = p; ack = a; clr = c; rst_n = r;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   // Acks channel ch whenever it is presented until idle; returns the number of accepted acks.
   task automatic drain(input int ch, output int acks);
      int n;
      acks = 0;
      n = 0;
      while (busy && n < 200) begin
         if (valid[ch]) acks++;
         cyc('0, valid & (NB'(1) << ch), 1'b0, 1'b1);
         n++;
      end
      check("drain_timeout", 32'(n >= 200), 32'd0);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < NB; i++) begin
            check($sformatf("valid[%0d]", i), 32'(valid[i]), 32'(m_pres[i]));
            check($sformatf("ovf[%0d]", i), 32'(ovf[i]), 32'(m_ovf[i]));
         end
         check("busy", 32'(busy), 32'(m_busy));
      end
   end

   initial begin
      int acks;
      pulse = '0; ack = '0; clr = 1'b0; rst_n = 1'b0;
      for (int i = 0; i < NB; i++) begin
         m_cnt[i] = 0; m_pres[i] = 0; m_gap[i] = 0; m_ovf[i] = 0;
      end
      m_busy = 0;
      @(negedge clk);
      cyc('0, '0, 1'b0, 1'b0);
      // Pulses and acks during reset must be ignored.
      cyc('1, '1, 1'b0, 1'b0);
      chk_en = 1'b1;
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      $display("txn reset done");

      // Single event on ch0: valid one cycle after the pulse, drop right after the ack.
      cyc(3'b001, '0, 1'b0, 1'b1);
      check("c0_valid_rise", 32'(valid), 32'd1);
      check("c0_busy", 32'(busy), 32'd1);
      repeat (3) cyc('0, '0, 1'b0, 1'b1);
      check("c0_valid_hold", 32'(valid), 32'd1);
      cyc('0, 3'b001, 1'b0, 1'b1);
      check("c0_valid_fall", 32'(valid), 32'd0);
      check("c0_busy_fall", 32'(busy), 32'd0);
      $display("txn ch0 single event");

      // Three pulses on ch1 produce three separate presentations.
      cyc(3'b010, '0, 1'b0, 1'b1);
      cyc(3'b010, '0, 1'b0, 1'b1);
      cyc(3'b010, '0, 1'b0, 1'b1);
      drain(1, acks);
      check("c1_three_acks", 32'(acks), 32'd3);
      check("c1_idle_busy", 32'(busy), 32'd0);
      $display("txn ch1 three events acks=%0d", acks);

      // 17 pulses on ch2 without ack saturate at 15.
      repeat (17) cyc(3'b100, '0, 1'b0, 1'b1);
      cyc('0, '0, 1'b0, 1'b1);
      check("c2_ovf_set", 32'(ovf[2]), 32'(OVF_EN));
      cyc('0, '0, 1'b1, 1'b1);
      check("c2_ovf_clr", 32'(ovf[2]), 32'd0);
      drain(2, acks);
      check("c2_sat_acks", 32'(acks), 32'(MAX));
      $display("txn ch2 saturation acks=%0d", acks);

      // Pulse plus ack at saturation on ch0: no overflow, GAP then PEND, count stays 15.
      repeat (15) cyc(3'b001, '0, 1'b0, 1'b1);
      cyc(3'b001, 3'b001, 1'b0, 1'b1);
      check("c0_sat_gap", 32'(valid[0]), 32'd0);
      check("c0_sat_noovf", 32'(ovf[0]), 32'd0);
      cyc('0, '0, 1'b0, 1'b1);
      check("c0_sat_pend", 32'(valid[0]), 32'd1);
      drain(0, acks);
      check("c0_sat_acks", 32'(acks), 32'(MAX));
      $display("txn ch0 pulse+ack at saturation acks=%0d", acks);

      // Reset mid-handshake discards pending events.
      repeat (3) cyc(3'b001, '0, 1'b0, 1'b1);
      cyc('0, '0, 1'b0, 1'b0);
      check("rst_mid_valid", 32'(valid[0]), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      cyc('0, 3'b001, 1'b0, 1'b1);
      check("rst_mid_ack_valid", 32'(valid[0]), 32'd0);
      check("rst_mid_ack_busy", 32'(busy), 32'd0);
      $display("txn reset mid-handshake");

      // Acks on ch1 in IDLE and in GAP are ignored.
      cyc('0, 3'b010, 1'b0, 1'b1);
      check("c1_idle_ack_valid", 32'(valid[1]), 32'd0);
      check("c1_idle_ack_busy", 32'(busy), 32'd0);
      cyc(3'b010, '0, 1'b0, 1'b1);
      cyc(3'b010, '0, 1'b0, 1'b1);
      cyc('0, 3'b010, 1'b0, 1'b1);
      check("c1_gap_valid", 32'(valid[1]), 32'd0);
      cyc('0, 3'b010, 1'b0, 1'b1);
      check("c1_after_gap_valid", 32'(valid[1]), 32'd1);
      drain(1, acks);
      check("c1_gap_acks", 32'(acks), 32'd1);
      $display("txn ch1 ignored acks");

      // Randomized traffic; alternating phases of sparse and heavy acking reach saturation.
      for (int k = 0; k < 4000; k++) begin
         logic [NB-1:0] p, a;
         int ack_pct;
         ack_pct = ((k / 400) % 2 == 0) ? 60 : 5;
         for (int i = 0; i < NB; i++) begin
            p[i] = ($urandom_range(99) < 45);
            a[i] = ($urandom_range(99) < ack_pct);
         end
         cyc(p, a, ($urandom_range(31) == 0), ($urandom_range(299) != 0));
      end
      $display("txn random traffic done");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
